// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one execute-stage ALU among N requesters.
// Drives a clean clk-aligned ALU capture pulse with operands held stable around it.
module alu_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  input  logic [N*3-1:0]    req_op,
  output logic [N-1:0]      resp_valid,
  input  logic [N-1:0]      resp_ready,
  output logic [31:0]       resp_data,
  output logic              alu_en,
  output logic              alu_pc_en,
  output logic              alu_imm_en,
  output logic [31:0]       alu_pc,
  output logic [31:0]       alu_imm,
  output logic [31:0]       alu_reg_1,
  output logic [31:0]       alu_reg_2,
  output logic [2:0]        alu_aluop,
  input  logic [31:0]       alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic [1:0]        dbg_state_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q;
  logic [PTR_W-1:0]   win, cand;
  logic               found;
  logic               accept;
  logic               resp_hs;
  logic               resp_vld_q;
  logic [31:0]        resp_data_q;
  logic [31:0]        reg_1_q, reg_2_q;
  logic [2:0]         aluop_q;
  logic               alu_en_q;
  logic [CNT_W-1:0]   op_count_q;
  logic [31:0]        a_arr  [N];
  logic [31:0]        b_arr  [N];
  logic [2:0]         op_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_arr[i]  = req_a[32*i +: 32];
    assign b_arr[i]  = req_b[32*i +: 32];
    assign op_arr[i] = req_op[3*i +: 3];
  end

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Handshakes: a transfer happens on the clk edge where valid & ready are both
  // high; req_ready is offered only in IDLE, resp_valid holds until resp_ready.
  assign accept  = (state_q == IDLE) && found;
  assign resp_hs = resp_vld_q && resp_ready[grant_q];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          rr_ptr_d = (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
        end
      end
      SETUP:   state_d = FIRE;
      FIRE:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q     <= '0;
      reg_1_q     <= '0;
      reg_2_q     <= '0;
      aluop_q     <= '0;
      alu_en_q    <= 1'b0;
      op_count_q  <= '0;
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        grant_q <= win;
        reg_1_q <= a_arr[win];
        reg_2_q <= b_arr[win];
        aluop_q <= op_arr[win];
      end
      // Registered so the ALU sees a glitch-free pulse covering the FIRE cycle.
      alu_en_q <= (state_d == FIRE);
      if (state_q == FIRE && op_count_q != '1) begin
        op_count_q <= op_count_q + 1'b1;
      end
      if (state_q == RESP) begin
        if (!resp_vld_q) begin
          resp_vld_q  <= 1'b1;
          resp_data_q <= alu_result;
        end else if (resp_ready[grant_q]) begin
          resp_vld_q  <= 1'b0;
        end
      end
    end
  end

  assign req_ready   = accept ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
  assign resp_valid  = resp_vld_q ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign resp_data   = resp_data_q;
  assign alu_en      = alu_en_q;
  assign alu_reg_1   = reg_1_q;
  assign alu_reg_2   = reg_2_q;
  assign alu_aluop   = aluop_q;
  assign alu_pc_en   = 1'b0;
  assign alu_imm_en  = 1'b0;
  assign alu_pc      = '0;
  assign alu_imm     = '0;
  assign busy        = (state_q != IDLE);
  assign op_count    = op_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: behavioural ALU, round-robin reference model
// with an expected-response queue, directed scenarios plus randomized traffic.
module tb_alu_arbiter;

  localparam int N       = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int IW      = 3;
  localparam int EW      = IW + 32;

  logic              clk;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N*3-1:0]    req_op;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [31:0]       resp_data;
  logic              alu_en;
  logic              alu_pc_en;
  logic              alu_imm_en;
  logic [31:0]       alu_pc;
  logic [31:0]       alu_imm;
  logic [31:0]       alu_reg_1;
  logic [31:0]       alu_reg_2;
  logic [2:0]        alu_aluop;
  logic [31:0]       alu_result;
  logic              busy;
  logic [CNT_W-1:0]  op_count;
  logic [1:0]        dbg_state_o;

  alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_en(alu_en), .alu_pc_en(alu_pc_en), .alu_imm_en(alu_imm_en),
    .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_reg_1(alu_reg_1), .alu_reg_2(alu_reg_2), .alu_aluop(alu_aluop),
    .alu_result(alu_result),
    .busy(busy), .op_count(op_count), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU behaviour (captures on rising alu_en) ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  initial alu_result = 32'd0;
  always @(posedge alu_en) alu_result <= alu_f(alu_reg_1, alu_reg_2, alu_aluop);

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_ptr = 0;
  int model_ops = 0;
  int acc_cyc = -100;
  int prev_acc = -100;
  int n_resp = 0;
  bit model_busy = 0;
  bit contention = 0;
  bit rand_ops = 0;
  logic [31:0] last_data = '0;
  int last_idx = -1;
  int grant_log[$];
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin : mon
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    int w;
    cyc++;
    check("alu_pc", alu_pc, 0);
    check("alu_imm", alu_imm, 0);
    check("const_en", {alu_pc_en, alu_imm_en}, 0);
    if (!rst) begin
      model_busy = 0;
      model_ptr  = 0;
      model_ops  = 0;
      acc_cyc    = -100;
      prev_acc   = -100;
      exp_q.delete();
      check("rst_outputs", {busy, alu_en, resp_valid, req_ready, op_count}, 0);
    end else begin
      check("busy", busy, model_busy);
      check("alu_en", alu_en, (model_busy && cyc == acc_cyc + 2));
      if (model_busy && cyc == acc_cyc + 3 && model_ops < CNT_MAX) model_ops++;
      check("op_count", op_count, model_ops);

      exp_ready = '0;
      w = -1;
      if (!model_busy) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (model_ptr + k) % N;
          if (w < 0 && req_valid[i]) w = i;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);

      exp_rv = '0;
      if (model_busy && cyc >= acc_cyc + 4 && exp_q.size() > 0) exp_rv[exp_q[0][32 +: IW]] = 1'b1;
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv != '0) check("resp_data", resp_data, exp_q[0][31:0]);

      if ((resp_valid & resp_ready & exp_rv) != '0) begin
        last_data  = exp_q[0][31:0];
        last_idx   = int'(exp_q[0][32 +: IW]);
        void'(exp_q.pop_front());
        model_busy = 0;
        n_resp++;
      end

      if (w >= 0) begin
        exp_q.push_back({IW'(w), alu_f(req_a[w*32 +: 32], req_b[w*32 +: 32], req_op[w*3 +: 3])});
        if (contention && prev_acc >= 0) check("grant_gap", cyc - prev_acc, 5);
        grant_log.push_back(w);
        prev_acc   = cyc;
        acc_cyc    = cyc;
        model_busy = 1;
        model_ptr  = (w + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ops) begin
      for (int i = 0; i < N; i++) begin
        req_a[i*32 +: 32] = $urandom;
        req_b[i*32 +: 32] = $urandom;
        req_op[i*3 +: 3]  = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    bit timeout;
    timeout = 1;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_op[idx*3 +: 3]  = op;
    req_valid[idx]      = 1'b1;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (req_ready[idx]) begin
        timeout = 0;
        tick();
        break;
      end
      tick();
    end
    req_valid[idx] = 1'b0;
    check("accept_timeout", timeout, 0);
  endtask

  task automatic wait_idle();
    bit timeout;
    timeout = 1;
    for (int t = 0; t < 200; t++) begin
      if (!busy && resp_valid == '0) begin
        timeout = 0;
        break;
      end
      tick();
    end
    check("idle_timeout", timeout, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit timeout;
    req_valid  = '0;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_regs", {alu_reg_1, alu_reg_2, alu_aluop}, 0);
    check("rst_data", resp_data, 0);
    check("rst_state", dbg_state_o, 0);
    rst = 1'b1;
    tick();

    // single ADD
    issue(0, 32'd5, 32'd3, 3'd3);
    wait_idle();
    check("single_data", last_data, 32'd8);
    check("single_idx", last_idx, 0);
    check("single_cnt", op_count, 1);

    // contention from rr_ptr=0
    do_reset();
    grant_log.delete();
    contention = 1;
    rand_ops   = 1;
    req_valid  = '1;
    repeat (30) tick();
    contention = 0;
    req_valid  = '0;
    wait_idle();
    rand_ops   = 0;
    check("rr_count", grant_log.size() >= 5, 1);
    check("rr_g0", grant_log[0], 0);
    check("rr_g1", grant_log[1], 1);
    check("rr_g2", grant_log[2], 2);
    check("rr_g3", grant_log[3], 3);
    check("rr_g4", grant_log[4], 0);

    // backpressure on requester 2, others contending and other resp_ready bits high
    issue(2, 32'd2, 32'd7, 3'd4);
    req_valid[1:0] = 2'b11;
    resp_ready     = 4'b1011;
    timeout = 1;
    for (int t = 0; t < 20; t++) begin
      if (resp_valid[2]) begin
        timeout = 0;
        break;
      end
      tick();
    end
    check("bp_timeout", timeout, 0);
    repeat (10) tick();
    check("bp_data", resp_data, 32'hFFFF_FFFB);
    check("bp_busy", busy, 1);
    check("bp_ready", req_ready, 0);
    resp_ready[2] = 1'b1;
    tick();
    check("bp_idle", dbg_state_o, 0);
    tick();
    req_valid = '0;
    wait_idle();

    // illegal opcode forwards zero
    issue(1, 32'hDEAD_BEEF, 32'h1234_5678, 3'd7);
    wait_idle();
    check("illegal_data", last_data, 0);
    check("illegal_idx", last_idx, 1);

    // reset while alu_en is high
    issue(3, 32'd9, 32'd4, 3'd3);
    timeout = 1;
    for (int t = 0; t < 10; t++) begin
      if (alu_en) begin
        timeout = 0;
        break;
      end
      tick();
    end
    check("fire_timeout", timeout, 0);
    rst = 1'b0;
    #1;
    check("abort_alu_en", alu_en, 0);
    check("abort_busy", busy, 0);
    check("abort_regs", {alu_reg_1, alu_reg_2, alu_aluop, resp_data}, 0);
    check("abort_cnt", op_count, 0);
    tick();
    req_valid = 4'b1010;
    rst = 1'b1;
    #1;
    check("abort_state", dbg_state_o, 0);
    check("abort_ptr", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle();

    // randomized traffic
    rand_ops = 1;
    for (int t = 0; t < 400; t++) begin
      req_valid  = N'($urandom_range(0, 15));
      resp_ready = N'($urandom_range(0, 15));
      tick();
    end
    req_valid  = '0;
    resp_ready = '1;
    wait_idle();

    // counter saturation
    do_reset();
    req_valid = '1;
    repeat (5 * (CNT_MAX + 6)) tick();
    req_valid = '0;
    wait_idle();
    rand_ops = 0;
    check("sat_cnt", op_count, CNT_MAX);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
